// File: rtl/mux_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_controller_if
// Description : Control, mux-return and sample bus of the mux scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_scan_controller_if #(
    parameter int DWELL_W = 8,
    parameter int DATA_W  = 2
);
    logic               en;
    logic               manual;
    logic [1:0]         manual_sel;
    logic [3:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [DATA_W-1:0]  mux_x;
    logic [1:0]         sel;
    logic [DATA_W-1:0]  sample;
    logic [1:0]         sample_ch;
    logic               sample_valid;
    logic               busy;

    modport master (
        input  en, manual, manual_sel, mask, dwell, mux_x,
        output sel, sample, sample_ch, sample_valid, busy
    );

    modport slave (
        output en, manual, manual_sel, mask, dwell, mux_x,
        input  sel, sample, sample_ch, sample_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/mux_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_controller
// Description : Steps a 4:1 mux select with per-channel settle time and
//               captures the returned data as a channel-tagged sample.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_controller #(
    parameter int DWELL_W = 8,
    parameter int DATA_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_scan_controller_if.master bus
);
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SETTLE  = 2'd1;
    localparam logic [1:0] c_CAPTURE = 2'd2;

    logic [1:0]         r_state;
    logic [DWELL_W-1:0] r_cnt;
    logic [1:0]         r_sel;
    logic [DATA_W-1:0]  r_sample;
    logic [1:0]         r_sample_ch;
    logic               r_valid;
    logic               r_busy;

    logic [1:0]         w_state;
    logic [DWELL_W-1:0] w_cnt;
    logic [1:0]         w_sel;
    logic [DATA_W-1:0]  w_sample;
    logic [1:0]         w_sample_ch;
    logic               w_valid;
    logic               w_run;
    logic [1:0]         w_pick;

    // First enabled channel after cur, wrapping back to cur itself last.
    function automatic logic [1:0] f_next_ch(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] ch;
        f_next_ch = cur;
        for (int i = 4; i >= 1; i--) begin
            ch = cur + 2'(i);
            if (m[ch]) f_next_ch = ch;
        end
    endfunction

    assign w_run = bus.en && (bus.manual || (bus.mask != 4'd0));

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_sel       = r_sel;
        w_sample    = r_sample;
        w_sample_ch = r_sample_ch;
        w_valid     = 1'b0;
        w_pick      = 2'd0;
        case (r_state)
            c_IDLE: begin
                if (w_run) begin
                    // Searching from channel 3 makes channel 0 the first candidate.
                    w_pick  = f_next_ch(2'd3, bus.mask);
                    w_sel   = bus.manual ? bus.manual_sel : w_pick;
                    w_cnt   = '0;
                    w_state = c_SETTLE;
                end
            end
            c_SETTLE: begin
                if (!w_run) begin
                    w_state = c_IDLE;
                end else if (r_cnt >= bus.dwell) begin
                    w_state = c_CAPTURE;
                end else begin
                    w_cnt = r_cnt + DWELL_W'(1);
                end
            end
            c_CAPTURE: begin
                if (!w_run) begin
                    w_state = c_IDLE;
                end else begin
                    w_pick      = f_next_ch(r_sel, bus.mask);
                    w_sample    = bus.mux_x;
                    w_sample_ch = r_sel;
                    w_valid     = 1'b1;
                    w_sel       = bus.manual ? bus.manual_sel : w_pick;
                    w_cnt       = '0;
                    w_state     = c_SETTLE;
                end
            end
            default: begin
                w_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_sel       <= 2'd0;
            r_sample    <= '0;
            r_sample_ch <= 2'd0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_sel       <= w_sel;
            r_sample    <= w_sample;
            r_sample_ch <= w_sample_ch;
            r_valid     <= w_valid;
            r_busy      <= (w_state != c_IDLE);
        end
    end

    assign bus.sel          = r_sel;
    assign bus.sample       = r_sample;
    assign bus.sample_ch    = r_sample_ch;
    assign bus.sample_valid = r_valid;
    assign bus.busy         = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_mux_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_controller
// Description : Bench for mux_scan_controller: cycle model plus directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_controller;
    localparam int DWELL_W = 8;
    localparam int DATA_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_scan_controller_if #(.DWELL_W(DWELL_W), .DATA_W(DATA_W)) bus();

    mux_scan_controller #(.DWELL_W(DWELL_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Mux returns {sel[0], sel[1]} for each channel.
    logic [DATA_W-1:0] ch_data [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    assign bus.mux_x = ch_data[bus.sel];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int rel    = 0;

    typedef struct {
        int                cyc;
        logic [1:0]        ch;
        logic [DATA_W-1:0] smp;
    } strobe_t;
    strobe_t strobes [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_strobe(input string name, input int idx, input int dcyc,
                              input int ch, input int smp);
        if (idx >= strobes.size()) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: strobe %0d missing, got %0d strobes, expected at rel+%0d",
                     name, idx, strobes.size(), dcyc);
        end else begin
            chk({name, "_cyc"}, strobes[idx].cyc - rel, dcyc);
            chk({name, "_ch"},  32'(strobes[idx].ch),  ch);
            chk({name, "_smp"}, 32'(strobes[idx].smp), smp);
        end
    endtask

    // First enabled channel scanning start, start+1, ... modulo 4.
    function automatic logic [1:0] pick(input logic [3:0] m, input int start);
        for (int i = 0; i < 4; i++)
            if (m[(start + i) % 4]) return 2'((start + i) % 4);
        return 2'(start % 4);
    endfunction

    // Behavioural model: channel age counts settle cycles, 'done' marks the
    // capture cycle, and the sample is taken from the mux data table.
    bit                started = 1'b0;
    bit                m_busy  = 1'b0;
    bit                m_done  = 1'b0;
    bit                m_valid = 1'b0;
    int                m_age   = 0;
    logic [1:0]        m_sel   = 2'd0;
    logic [1:0]        m_sch   = 2'd0;
    logic [DATA_W-1:0] m_sample = '0;
    bit                run;

    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
        run     = bus.en && (bus.manual || bus.mask != 4'd0);
        m_valid = 1'b0;
        if (rst) begin
            m_busy = 0; m_done = 0; m_age = 0;
            m_sel = 0; m_sch = 0; m_sample = '0;
        end else if (!m_busy) begin
            if (run) begin
                m_busy = 1; m_done = 0; m_age = 0;
                m_sel  = bus.manual ? bus.manual_sel : pick(bus.mask, 0);
            end
        end else if (!run) begin
            m_busy = 0;
            m_done = 0;
        end else if (m_done) begin
            m_valid  = 1;
            m_sch    = m_sel;
            m_sample = ch_data[m_sel];
            m_sel    = bus.manual ? bus.manual_sel : pick(bus.mask, int'(m_sel) + 1);
            m_age    = 0;
            m_done   = 0;
        end else if (m_age >= int'(bus.dwell)) begin
            m_done = 1;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("sel",          32'(bus.sel),          32'(m_sel));
            chk("sample",       32'(bus.sample),       32'(m_sample));
            chk("sample_ch",    32'(bus.sample_ch),    32'(m_sch));
            chk("sample_valid", 32'(bus.sample_valid), 32'(m_valid));
            chk("busy",         32'(bus.busy),         32'(m_busy));
            if (bus.sample_valid === 1'b1)
                strobes.push_back('{cyc, bus.sample_ch, bus.sample});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic restart();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        rel = cyc;
        strobes.delete();
    endtask

    initial begin
        bus.en = 1'b1; bus.manual = 1'b0; bus.manual_sel = 2'd0;
        bus.mask = 4'hF; bus.dwell = 8'd2;

        // Reset held with scanning requested, then released.
        step(3);
        chk("rst_busy",  32'(bus.busy),         0);
        chk("rst_valid", 32'(bus.sample_valid), 0);
        chk("rst_sel",   32'(bus.sel),          0);
        rst = 1'b0; rel = cyc; strobes.delete();
        step(10);
        chk_strobe("first", 0, 5, 0, 2'b00);
        chk_strobe("second", 1, 9, 1, 2'b10);

        // Round robin over channels 0,1,3.
        bus.mask = 4'b1011;
        restart();
        step(18);
        chk_strobe("rr0", 0, 5,  0, 2'b00);
        chk_strobe("rr1", 1, 9,  1, 2'b10);
        chk_strobe("rr3", 2, 13, 3, 2'b11);
        chk_strobe("rr0b", 3, 17, 0, 2'b00);

        // Single channel 3, minimum dwell.
        bus.mask = 4'b1000; bus.dwell = 8'd0;
        restart();
        step(8);
        chk_strobe("one_a", 0, 3, 3, 2'b11);
        chk_strobe("one_b", 1, 5, 3, 2'b11);
        chk_strobe("one_c", 2, 7, 3, 2'b11);

        // Manual channel 2, then auto with only channel 0 mid-settle.
        bus.manual = 1'b1; bus.manual_sel = 2'd2; bus.mask = 4'b0000; bus.dwell = 8'd1;
        restart();
        step(8);
        bus.manual = 1'b0; bus.mask = 4'b0001;
        step(6);
        chk_strobe("man_a", 0, 4,  2, 2'b01);
        chk_strobe("man_b", 1, 7,  2, 2'b01);
        chk_strobe("man_c", 2, 10, 2, 2'b01);
        chk_strobe("auto0", 3, 13, 0, 2'b00);

        // Abort by en low, then by an empty mask.
        bus.mask = 4'b0100; bus.dwell = 8'd5;
        restart();
        step(3);
        bus.en = 1'b0;
        step(1);
        chk("en_abort_busy", 32'(bus.busy), 0);
        chk("en_abort_sel",  32'(bus.sel),  2);
        bus.en = 1'b1;
        step(3);
        bus.mask = 4'b0000;
        step(1);
        chk("mask_abort_busy", 32'(bus.busy), 0);
        chk("mask_abort_sel",  32'(bus.sel),  2);
        chk("abort_no_strobe", 32'(strobes.size()), 0);

        // Reset landing in the capture cycle.
        bus.mask = 4'b0100; bus.dwell = 8'd0;
        restart();
        step(2);
        chk("pre_rst_sel",  32'(bus.sel),  2);
        chk("pre_rst_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        step(1);
        chk("cap_rst_sel",   32'(bus.sel),          0);
        chk("cap_rst_busy",  32'(bus.busy),         0);
        chk("cap_rst_valid", 32'(bus.sample_valid), 0);
        step(1);
        chk("cap_rst_no_strobe", 32'(strobes.size()), 0);

        // Dwell shrunk from 10 to 1 while counter is at 5.
        bus.mask = 4'b0011; bus.dwell = 8'd10;
        restart();
        step(6);
        bus.dwell = 8'd1;
        step(8);
        chk_strobe("shrink0", 0, 8,  0, 2'b00);
        chk_strobe("shrink1", 1, 11, 1, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
